// File: rtl/ma_tile_feeder_if.sv
// Row-stream handshake into the MA tile feeder: tile config, valid/ready, row kind and row data.
interface ma_tile_feeder_if #(
  parameter int unsigned data_length = 8,
  parameter int unsigned mesh_length = 16,
  parameter int unsigned row_w       = 9
);
  logic [row_w-1:0]                   cfg_rows;
  logic                               s_valid;
  logic                               s_ready;
  logic                               s_kind;
  logic [data_length*mesh_length-1:0] s_data;

  modport master (
    output cfg_rows,
    output s_valid,
    output s_kind,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  cfg_rows,
    input  s_valid,
    input  s_kind,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/ma_tile_feeder.sv
// Sequences a weight-then-image row stream into the MA systolic mesh, with optional
// diagonal lane skew on the image path, a drain phase and protocol-error reporting.
module ma_tile_feeder #(
  parameter int unsigned data_length = 8,
  parameter int unsigned mesh_length = 16,
  parameter int unsigned max_rows    = 256,
  parameter bit          skew_en     = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  ma_tile_feeder_if.slave                    s,
  output logic [data_length*mesh_length-1:0] ma_weight,
  output logic                               ma_weight_load,
  output logic [data_length*mesh_length-1:0] ma_image,
  output logic                               ma_image_load,
  output logic                               busy,
  output logic                               tile_done,
  output logic                               proto_err
);
  localparam int unsigned RowW     = $clog2(max_rows + 1);
  localparam int unsigned CntW     = $clog2(mesh_length + 1);
  localparam int unsigned DrainLen = skew_en ? mesh_length : 1;
  localparam int unsigned LaneW    = data_length + 1;

  typedef enum logic [1:0] {StIdle, StWLoad, StIStream, StDrain} state_e;

  state_e            state_q;
  logic [RowW-1:0]   rows_left_q;
  logic [CntW-1:0]   w_cnt_q;
  logic [CntW-1:0]   d_cnt_q;

  logic              acc;
  logic              acc_w;
  logic              acc_i;
  logic              cfg_ok;
  logic              img_push;
  logic [mesh_length-1:0] lane_vld;

  assign s.s_ready = (state_q != StDrain);
  assign busy      = (state_q != StIdle);
  assign acc       = s.s_valid && s.s_ready;
  assign acc_w     = acc && !s.s_kind;
  assign acc_i     = acc && s.s_kind;
  assign cfg_ok    = (s.cfg_rows != '0) && (32'(s.cfg_rows) <= max_rows);
  assign img_push  = acc_i && (state_q == StIStream);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      rows_left_q    <= '0;
      w_cnt_q        <= '0;
      d_cnt_q        <= '0;
      ma_weight      <= '0;
      ma_weight_load <= 1'b0;
      tile_done      <= 1'b0;
      proto_err      <= 1'b0;
    end else begin
      ma_weight_load <= 1'b0;
      tile_done      <= 1'b0;
      proto_err      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (acc_w && cfg_ok) begin
            rows_left_q    <= RowW'(s.cfg_rows);
            w_cnt_q        <= CntW'(1);
            ma_weight      <= s.s_data;
            ma_weight_load <= 1'b1;
            state_q        <= (mesh_length == 1) ? StIStream : StWLoad;
          end else if (acc) begin
            proto_err <= 1'b1;
          end
        end
        StWLoad: begin
          if (acc_w) begin
            ma_weight      <= s.s_data;
            ma_weight_load <= 1'b1;
            if (w_cnt_q == CntW'(mesh_length - 1)) begin
              state_q <= StIStream;
            end else begin
              w_cnt_q <= w_cnt_q + CntW'(1);
            end
          end else if (acc_i) begin
            proto_err <= 1'b1;
          end
        end
        StIStream: begin
          if (acc_i) begin
            rows_left_q <= rows_left_q - RowW'(1);
            if (rows_left_q == RowW'(1)) begin
              state_q <= StDrain;
              d_cnt_q <= '0;
            end
          end else if (acc_w) begin
            proto_err <= 1'b1;
          end
        end
        StDrain: begin
          // Hold off new tiles until the most-delayed lane has left the skew pipe.
          if (d_cnt_q == CntW'(DrainLen - 1)) begin
            state_q   <= StIdle;
            tile_done <= 1'b1;
          end else begin
            d_cnt_q <= d_cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Lane k is a (k+1)-deep shift of {valid, data}; invalid slots carry zero data.
  for (genvar k = 0; k < mesh_length; k++) begin : g_lane
    localparam int unsigned Depth = skew_en ? k + 1 : 1;

    logic [Depth*LaneW-1:0] pipe_q;
    logic [LaneW-1:0]       pipe_in;

    assign pipe_in = {img_push, img_push ? s.s_data[k*data_length +: data_length]
                                         : {data_length{1'b0}}};

    if (Depth == 1) begin : g_d1
      always_ff @(posedge clk) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= pipe_in;
      end
    end else begin : g_dn
      always_ff @(posedge clk) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= {pipe_q[(Depth-1)*LaneW-1:0], pipe_in};
      end
    end

    assign ma_image[k*data_length +: data_length] = pipe_q[(Depth-1)*LaneW +: data_length];
    assign lane_vld[k] = pipe_q[Depth*LaneW-1];
  end

  assign ma_image_load = |lane_vld;
endmodule

// File: tb/tb_ma_tile_feeder.sv
// Directed bench for ma_tile_feeder: one skewed and one unskewed instance share stimulus,
// selected by sel; a small acceptance log models the expected image diagonal.
module tb_ma_tile_feeder;
  localparam int unsigned DL = 8;
  localparam int unsigned ML = 16;
  localparam int unsigned RW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          sel  = 1'b0;
  logic [RW-1:0] cfg  = '0;
  logic          vld  = 1'b0;
  logic          kind = 1'b0;
  logic [127:0]  data = '0;

  ma_tile_feeder_if #(.data_length(DL), .mesh_length(ML), .row_w(RW)) if0 ();
  ma_tile_feeder_if #(.data_length(DL), .mesh_length(ML), .row_w(RW)) if1 ();

  assign if0.cfg_rows = cfg;
  assign if0.s_valid  = vld & ~sel;
  assign if0.s_kind   = kind;
  assign if0.s_data   = data;
  assign if1.cfg_rows = cfg;
  assign if1.s_valid  = vld & sel;
  assign if1.s_kind   = kind;
  assign if1.s_data   = data;

  logic [127:0] w0, w1, im0, im1;
  logic wl0, wl1, il0, il1, bz0, bz1, td0, td1, pe0, pe1;

  ma_tile_feeder #(.data_length(DL), .mesh_length(ML), .max_rows(256), .skew_en(1'b1)) dut0 (
    .clk(clk), .rst(rst), .s(if0.slave),
    .ma_weight(w0), .ma_weight_load(wl0), .ma_image(im0), .ma_image_load(il0),
    .busy(bz0), .tile_done(td0), .proto_err(pe0)
  );

  ma_tile_feeder #(.data_length(DL), .mesh_length(ML), .max_rows(256), .skew_en(1'b0)) dut1 (
    .clk(clk), .rst(rst), .s(if1.slave),
    .ma_weight(w1), .ma_weight_load(wl1), .ma_image(im1), .ma_image_load(il1),
    .busy(bz1), .tile_done(td1), .proto_err(pe1)
  );

  logic [127:0] o_w, o_im;
  logic o_wl, o_il, o_bz, o_td, o_pe, o_sr;
  assign o_w  = sel ? w1  : w0;
  assign o_im = sel ? im1 : im0;
  assign o_wl = sel ? wl1 : wl0;
  assign o_il = sel ? il1 : il0;
  assign o_bz = sel ? bz1 : bz0;
  assign o_td = sel ? td1 : td0;
  assign o_pe = sel ? pe1 : pe0;
  assign o_sr = sel ? if1.s_ready : if0.s_ready;

  int checks = 0;
  int fails  = 0;
  int n      = 0;

  // Acceptance log: edge index and lane value of every image row the DUT should take.
  int          acc_n[$];
  logic [7:0]  acc_v[$];
  bit          mskew;

  function automatic logic [127:0] exp_img(int t);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < acc_n.size(); i++)
        if (acc_n[i] + (mskew ? k : 0) == t) v[k*8 +: 8] = acc_v[i];
    return v;
  endfunction

  function automatic logic exp_ld(int t);
    logic r;
    r = 1'b0;
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < acc_n.size(); i++)
        if (acc_n[i] + (mskew ? k : 0) == t) r = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic send_weights(int unsigned rows);
    for (int i = 0; i < 16; i++) begin
      vld = 1'b1; kind = 1'b0; cfg = RW'(rows); data = {16{8'(i)}};
      tick();
    end
    vld = 1'b0;
  endtask

  task automatic send_image(int r);
    vld = 1'b1; kind = 1'b1; data = {16{8'(r)}};
    tick();
    acc_n.push_back(n);
    acc_v.push_back(8'(r));
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b0; sel = 1'b0;
    repeat (3) tick();
    checks++;
    if ({o_wl, o_il, o_td, o_pe, o_bz} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 00000", {o_wl, o_il, o_td, o_pe, o_bz});
    end
    checks++;
    if (o_w !== '0 || o_im !== '0) begin
      fails++; $display("FAIL reset_data: got w=%h im=%h want 0", o_w, o_im);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (o_sr !== 1'b1 || o_bz !== 1'b0) begin
      fails++; $display("FAIL reset_ready: got ready=%b busy=%b want 1 0", o_sr, o_bz);
    end
  endtask

  // Weight load followed by three back-to-back image rows and the skewed drain.
  task automatic test_skew_tile();
    int t;
    sel = 1'b0; mskew = 1'b1; acc_n.delete(); acc_v.delete();
    for (int i = 0; i < 16; i++) begin
      vld = 1'b1; kind = 1'b0; cfg = 9'd3; data = {16{8'(i)}};
      checks++;
      if (o_sr !== 1'b1) begin fails++; $display("FAIL w_ready[%0d]: got %b want 1", i, o_sr); end
      tick();
      checks++;
      if (o_wl !== 1'b1 || o_w !== {16{8'(i)}} || o_il !== 1'b0) begin
        fails++;
        $display("FAIL w_row[%0d]: got load=%b w=%h il=%b want 1 %h 0", i, o_wl, o_w, o_il,
                 {16{8'(i)}});
      end
    end
    for (int r = 1; r <= 3; r++) begin
      send_image(r);
      checks++;
      if (o_im !== exp_img(n) || o_il !== exp_ld(n) || o_wl !== 1'b0 || o_pe !== 1'b0) begin
        fails++;
        $display("FAIL img_row[%0d]: got im=%h il=%b wl=%b pe=%b want im=%h il=%b", r, o_im,
                 o_il, o_wl, o_pe, exp_img(n), exp_ld(n));
      end
    end
    t = n;
    for (int j = 1; j <= 17; j++) begin
      vld = (n + 1 <= t + 16);
      tick();
      checks++;
      if (o_im !== exp_img(n) || o_il !== exp_ld(n) || o_pe !== 1'b0 ||
          o_td !== (n == t + 16) || o_bz !== (n < t + 16) || o_sr !== (n >= t + 16)) begin
        fails++;
        $display("FAIL skew_drain[%0d]: got im=%h il=%b pe=%b td=%b bz=%b sr=%b want im=%h il=%b",
                 j, o_im, o_il, o_pe, o_td, o_bz, o_sr, exp_img(n), exp_ld(n));
      end
    end
    vld = 1'b0;
  endtask

  task automatic test_noskew_tile();
    int t;
    sel = 1'b1; mskew = 1'b0; acc_n.delete(); acc_v.delete();
    send_weights(3);
    for (int r = 1; r <= 3; r++) begin
      send_image(r);
      checks++;
      if (o_im !== {16{8'(r)}} || o_il !== 1'b1 || o_sr !== (r != 3)) begin
        fails++;
        $display("FAIL ns_row[%0d]: got im=%h il=%b sr=%b want %h 1 %b", r, o_im, o_il, o_sr,
                 {16{8'(r)}}, (r != 3));
      end
    end
    vld = 1'b0;
    t = n;
    for (int j = 1; j <= 3; j++) begin
      tick();
      checks++;
      if (o_im !== exp_img(n) || o_il !== exp_ld(n) || o_td !== (n == t + 1) ||
          o_bz !== (n < t + 1) || o_sr !== 1'b1) begin
        fails++;
        $display("FAIL ns_drain[%0d]: got im=%h il=%b td=%b bz=%b sr=%b", j, o_im, o_il, o_td,
                 o_bz, o_sr);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_proto_err();
    sel = 1'b0;
    vld = 1'b1; kind = 1'b1; data = {16{8'hAA}};
    tick();
    vld = 1'b0;
    checks++;
    if (o_pe !== 1'b1 || o_il !== 1'b0 || o_wl !== 1'b0 || o_bz !== 1'b0) begin
      fails++; $display("FAIL err_idle_img: got pe=%b il=%b wl=%b bz=%b want 1 0 0 0", o_pe,
                        o_il, o_wl, o_bz);
    end
    tick();
    checks++;
    if (o_pe !== 1'b0) begin fails++; $display("FAIL err_pulse: got %b want 0", o_pe); end
    for (int c = 0; c < 2; c++) begin
      vld = 1'b1; kind = 1'b0; cfg = (c == 0) ? 9'd0 : 9'd257; data = {16{8'h55}};
      tick();
      vld = 1'b0;
      checks++;
      if (o_pe !== 1'b1 || o_wl !== 1'b0 || o_bz !== 1'b0) begin
        fails++; $display("FAIL err_cfg[%0d]: got pe=%b wl=%b bz=%b want 1 0 0", c, o_pe, o_wl,
                          o_bz);
      end
      tick();
    end
  endtask

  // Bubble and a stray weight beat mid-stream: both must leave a zero diagonal, not a stall.
  task automatic test_bubble();
    int t;
    sel = 1'b0; mskew = 1'b1; acc_n.delete(); acc_v.delete();
    send_weights(3);
    send_image(1);
    vld = 1'b0;
    tick();
    checks++;
    if (o_im !== exp_img(n) || o_il !== 1'b1) begin
      fails++; $display("FAIL bubble: got im=%h il=%b want %h 1", o_im, o_il, exp_img(n));
    end
    vld = 1'b1; kind = 1'b0; data = {16{8'hEE}};
    tick();
    checks++;
    if (o_pe !== 1'b1 || o_wl !== 1'b0 || o_bz !== 1'b1 || o_im !== exp_img(n) ||
        o_il !== 1'b1) begin
      fails++; $display("FAIL err_stream_w: got pe=%b wl=%b bz=%b im=%h il=%b", o_pe, o_wl,
                        o_bz, o_im, o_il);
    end
    send_image(2);
    send_image(3);
    vld = 1'b0;
    t = n;
    for (int j = 1; j <= 17; j++) begin
      tick();
      checks++;
      if (o_im !== exp_img(n) || o_il !== exp_ld(n) || o_td !== (n == t + 16)) begin
        fails++;
        $display("FAIL bubble_drain[%0d]: got im=%h il=%b td=%b want im=%h il=%b", j, o_im,
                 o_il, o_td, exp_img(n), exp_ld(n));
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    sel = 1'b0; mskew = 1'b1; acc_n.delete(); acc_v.delete();
    send_weights(3);
    send_image(1);
    send_image(2);
    vld = 1'b0; rst = 1'b1;
    tick();
    checks++;
    if ({o_wl, o_il, o_td, o_pe, o_bz} !== 5'b0 || o_im !== '0 || o_w !== '0) begin
      fails++; $display("FAIL rst_mid: got flags=%b im=%h w=%h want 0",
                        {o_wl, o_il, o_td, o_pe, o_bz}, o_im, o_w);
    end
    rst = 1'b0;
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (o_td !== 1'b0 || o_il !== 1'b0 || o_pe !== 1'b0 || o_bz !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++; $display("FAIL rst_mid_after: got %0d bad cycles want 0", bad);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_skew_tile();
    test_noskew_tile();
    test_proto_err();
    test_bubble();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
